ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter: the other direction of the existing PS/2 keyboard receiver.
- Sends command bytes to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the inhibit/request-to-send sequence, device-clocked bit shifting, odd parity, and the device ACK.
- Drives the shared PS2_clk/PS2_data pins through open-drain enables.
- Asserts busy so the receiver ignores the bus during a host transmission.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_host_tx.sv | 182 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and its line filters.
// Latency: n/a (types, constants and a frame-building helper only).
// Backpressure: n/a.
package ps2_pkg;

  // Transmitter FSM encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // Failure codes reported alongside err
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Bits shifted after the start bit: 8 data, parity, stop
  localparam int FRAME_BITS = 10;

  typedef logic [FRAME_BITS-1:0] frame_t;

  // Frame as shifted LSB first: data byte, odd parity, stop bit
  function automatic frame_t make_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 pin and accepts a level only after FILTER_LEN stable samples.
// Latency: filtered level follows the pin 2+FILTER_LEN cycles later; fall fires the cycle before line_filt drops.
// Backpressure: none; free-running, shorter pulses are discarded.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_raw,
  output logic line_filt,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] stable_cnt;
  logic          settle;

  // The new level has been seen for FILTER_LEN consecutive samples
  assign settle = (sync_b != line_filt) && (stable_cnt == CW'(FILTER_LEN - 1));
  // Registered consumers act on the same edge that line_filt flips to 0
  assign fall   = settle && line_filt;

  // Two-flop synchronizer followed by the stability counter; idle bus level is 1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a     <= 1'b1;
      sync_b     <= 1'b1;
      line_filt  <= 1'b1;
      stable_cnt <= '0;
    end else begin
      sync_a <= line_raw;
      sync_b <= sync_a;
      if (sync_b == line_filt) begin
        stable_cnt <= '0;
      end else if (settle) begin
        line_filt  <= sync_b;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift, ACK check.
// Latency: INHIBIT_CYC+1 cycles to start bit, then paced by device clock; done/err one cycle after the deciding event.
// Backpressure: tx_ready only in IDLE, no queueing; build option PS2_HOST_TX_RETRY_EN retries a failed frame twice.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 12000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]       state;
  frame_t           frame;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] cnt;
  logic             data_oe_r;

  logic clk_filt;
  logic clk_fall;
  logic data_filt;
  logic data_fall_unused;  // data edges carry no meaning for the transmitter

  logic       in_dev;
  logic       line_idle;
  logic       progress;
  logic       fail_tmo;
  logic       fail_nack;
  logic       fail;
  logic [1:0] fail_code;

`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0] retry_cnt;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk       (clk),
    .rst       (rst),
    .line_raw  (ps2_clk_in),
    .line_filt (clk_filt),
    .fall      (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk       (clk),
    .rst       (rst),
    .line_raw  (ps2_data_in),
    .line_filt (data_filt),
    .fall      (data_fall_unused)
  );

  // Failure detection: device NACK, or device went silent while it owns the clock
  always_comb begin
    in_dev    = (state == ST_SHIFT) || (state == ST_ACK) || (state == ST_WAIT_IDLE);
    line_idle = clk_filt && data_filt;
    progress  = clk_fall || ((state == ST_WAIT_IDLE) && line_idle);
    fail_tmo  = in_dev && !progress && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    fail_nack = (state == ST_ACK) && clk_fall && data_filt;
    fail      = fail_tmo || fail_nack;
    fail_code = fail_nack ? ERR_NACK : ERR_TIMEOUT;
  end

  // Main sequencer: frame capture, bit shifting, timeout counting and result pulses
  always_ff @(posedge clk) begin
    done <= 1'b0;
    err  <= 1'b0;
    if (rst) begin
      state     <= ST_IDLE;
      frame     <= '0;
      bit_cnt   <= '0;
      cnt       <= '0;
      data_oe_r <= 1'b0;
      err_code  <= 2'b00;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_cnt <= 2'd0;
`endif
    end else if (fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
      if (retry_cnt != 2'd2) begin
        // Same byte again from the inhibit phase; frame register is untouched
        retry_cnt <= retry_cnt + 2'd1;
        state     <= ST_INHIBIT;
        cnt       <= '0;
        bit_cnt   <= '0;
        data_oe_r <= 1'b0;
      end else begin
        state     <= ST_IDLE;
        data_oe_r <= 1'b0;
        err       <= 1'b1;
        err_code  <= fail_code;
      end
`else
      state     <= ST_IDLE;
      data_oe_r <= 1'b0;
      err       <= 1'b1;
      err_code  <= fail_code;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            frame   <= make_frame(tx_data);
            state   <= ST_INHIBIT;
            cnt     <= '0;
            bit_cnt <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_cnt <= 2'd0;
`endif
          end
        end
        ST_INHIBIT: begin
          if (cnt == CNT_W'(INHIBIT_CYC - 1)) begin
            state <= ST_REQ;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REQ: begin
          // Start bit stays asserted after the clock is released
          state     <= ST_SHIFT;
          data_oe_r <= 1'b1;
          cnt       <= '0;
        end
        ST_SHIFT: begin
          if (clk_fall) begin
            data_oe_r <= ~frame[bit_cnt];
            cnt       <= '0;
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
              state   <= ST_ACK;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACK: begin
          // A high data line here is caught as NACK by the failure logic
          if (clk_fall) begin
            state <= ST_WAIT_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (line_idle) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready    = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign ps2_clk_oe  = (state == ST_INHIBIT) || (state == ST_REQ);
  assign ps2_data_oe = (state == ST_REQ) || ((state == ST_SHIFT) && data_oe_r);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model with a behavioural keyboard and result scoreboard.
// Latency: timings scaled down through parameters so every scenario finishes quickly.
// Backpressure: stimulus waits on tx_ready; every wait on the DUT is bounded.
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int TMO = 2000;
  localparam int FL  = 8;
  localparam int H   = 40;   // device clock half period in system cycles

  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_SILENT = 2;
  localparam int M_ABORT  = 3;
  localparam int M_GLITCH = 4;

  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
  } resp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_main;
  logic       dev_rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       dev_clk_low;
  logic       dev_data_low;

  resp_t exp_resp[$];
  logic  exp_bits[$];
  int    dev_q[$];
  int    n_checks   = 0;
  int    n_err      = 0;
  int    resp_seen  = 0;
  int    cyc        = 0;
  int    acc_cyc    = 0;
  logic  abort_done = 1'b0;
  logic  glitch_exp_oe;
  resp_t mon_r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rst         = rst_main | dev_rst;
  assign ps2_clk_in  = !(ps2_clk_oe || dev_clk_low);
  assign ps2_data_in = !(ps2_data_oe || dev_data_low);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILTER_LEN(FL)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected line levels seen by the device at rises 1..nbits: data LSB first, odd parity, stop
  function automatic void push_frame(input logic [7:0] d, input int nbits);
    logic [9:0] fb;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    fb = {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
    for (int i = 0; i < nbits; i++) exp_bits.push_back(fb[i]);
  endfunction

  // Result monitor: every done/err pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (done || err) begin
      check("done_err_exclusive", {31'd0, done & err}, 32'd0);
      if (exp_resp.size() == 0) begin
        check("unexpected_result", {30'd0, done, err}, 32'd0);
      end else begin
        mon_r = exp_resp.pop_front();
        check("result_is_err", {31'd0, err}, {31'd0, mon_r.is_err});
        if (mon_r.is_err) check("err_code", {30'd0, err_code}, {30'd0, mon_r.code});
      end
      resp_seen++;
    end
  end

  // Keyboard model: clocks the frame, samples host data before each rise, answers ACK
  task automatic run_dev(input int mode);
    int t;
    if (mode == M_SILENT) begin
      t = 0;
      while (busy && t < INH + TMO + 200) begin
        @(negedge clk);
        t++;
      end
      return;
    end
    repeat (H) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      if (mode == M_ABORT && k == 5) begin
        repeat (FL + 4) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        dev_rst     = 1'b1;
        dev_clk_low = 1'b0;
        @(negedge clk);
        check("abort_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("abort_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        dev_rst    = 1'b0;
        abort_done = 1'b1;
        return;
      end
      repeat (H) @(negedge clk);
      if (k <= 10) begin
        if (exp_bits.size() == 0) check("frame_bit_extra", 32'd1, 32'd0);
        else check("frame_bit", {31'd0, ps2_data_in}, {31'd0, exp_bits.pop_front()});
      end
      dev_clk_low = 1'b0;
      repeat (H / 2) @(negedge clk);
      if (mode == M_GLITCH && k == 3) begin
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (FL + 6) @(negedge clk);
        check("glitch_data_oe", {31'd0, ps2_data_oe}, {31'd0, glitch_exp_oe});
      end
      if (k == 10 && mode != M_NACK) dev_data_low = 1'b1;
      if (k == 11) dev_data_low = 1'b0;
      repeat (H / 2) @(negedge clk);
    end
    repeat (H) @(negedge clk);
  endtask

  // Device process: answers each host request-to-send with the next queued behaviour
  initial begin : device
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    dev_rst      = 1'b0;
    forever begin
      @(negedge clk);
      if (ps2_data_oe === 1'b1 && ps2_clk_oe === 1'b0 && busy === 1'b1 && dev_q.size() > 0)
        run_dev(dev_q.pop_front());
    end
  end

  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!tx_ready && t < 10000) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    int t;
    t = 0;
    while (resp_seen < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("result_arrived", resp_seen, target);
  endtask

  initial begin : stimulus
    int t;
    rst_main = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    rst_main = 1'b0;
    repeat (20) @(negedge clk);

    // 0xED with ACK: start bit timing, ten bits, done
    dev_q.push_back(M_ACK);
    push_frame(8'hED, 10);
    exp_resp.push_back('{is_err: 1'b0, code: 2'b00});
    send(8'hED);
    t = 0;
    while (!ps2_data_oe && t < INH + 50) begin
      @(negedge clk);
      t++;
    end
    check("start_bit_offset", cyc - acc_cyc, INH);
    check("start_bit_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
    wait_resp(1);
    repeat (3 * H) @(negedge clk);

    // 0x00 with NACK from the device
    dev_q.push_back(M_NACK);
    push_frame(8'h00, 10);
    exp_resp.push_back('{is_err: 1'b1, code: 2'b01});
    send(8'h00);
    wait_resp(2);
    @(negedge clk);
    check("nack_ready_after", {31'd0, tx_ready}, 32'd1);
    repeat (3 * H) @(negedge clk);

    // 0xFF with a silent device: timeout at a fixed offset from accept
    dev_q.push_back(M_SILENT);
    exp_resp.push_back('{is_err: 1'b1, code: 2'b10});
    send(8'hFF);
    t = 0;
    while (!err && t < INH + TMO + 100) begin
      @(negedge clk);
      t++;
    end
    check("timeout_offset", cyc - acc_cyc, INH + 1 + TMO);
    check("timeout_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("timeout_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    wait_resp(3);
    repeat (3 * H) @(negedge clk);

    // 0xF4 with tx_valid held and tx_data changed mid-frame; 0x55 follows right after done
    dev_q.push_back(M_ACK);
    dev_q.push_back(M_ACK);
    push_frame(8'hF4, 10);
    push_frame(8'h55, 10);
    exp_resp.push_back('{is_err: 1'b0, code: 2'b00});
    exp_resp.push_back('{is_err: 1'b0, code: 2'b00});
    @(negedge clk);
    tx_data  = 8'hF4;
    tx_valid = 1'b1;
    repeat (300) @(negedge clk);
    tx_data = 8'h55;
    t = 0;
    while (!done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("held_done_seen", {31'd0, done}, 32'd1);
    check("held_ready_at_done", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    check("held_second_accept", {31'd0, busy}, 32'd1);
    check("held_second_inhibit", {31'd0, ps2_clk_oe}, 32'd1);
    tx_valid = 1'b0;
    wait_resp(5);
    check("err_code_held", {30'd0, err_code}, 32'd2);
    repeat (3 * H) @(negedge clk);

    // Reset during the fifth device clock, then a clean 0xED
    dev_q.push_back(M_ABORT);
    push_frame(8'hED, 4);
    send(8'hED);
    t = 0;
    while (!abort_done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("abort_reached", {31'd0, abort_done}, 32'd1);
    repeat (100) @(negedge clk);
    check("abort_no_result", resp_seen, 5);
    dev_q.push_back(M_ACK);
    push_frame(8'hED, 10);
    exp_resp.push_back('{is_err: 1'b0, code: 2'b00});
    send(8'hED);
    wait_resp(6);
    repeat (3 * H) @(negedge clk);

    // 0x5A with a 3-cycle clock glitch after the third falling edge
    glitch_exp_oe = 1'b1;   // host drives ~bit2 of 0x5A, which is 0
    dev_q.push_back(M_GLITCH);
    push_frame(8'h5A, 10);
    exp_resp.push_back('{is_err: 1'b0, code: 2'b00});
    send(8'h5A);
    wait_resp(7);
    repeat (3 * H) @(negedge clk);

    check("bits_left", exp_bits.size(), 0);
    check("results_left", exp_resp.size(), 0);
    check("device_cmds_left", dev_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
